// File: rtl/int_div_pkg.sv
// ============================================================================
// Module : int_div_pkg
// Brief  : Shared op encodings, FSM states and constants for int_div_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package int_div_pkg;

   localparam int XLEN_DEF = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   localparam logic [1:0] OP_DIV  = 2'd0;
   localparam logic [1:0] OP_DIVU = 2'd1;
   localparam logic [1:0] OP_REM  = 2'd2;
   localparam logic [1:0] OP_REMU = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/int_div_seq_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One restoring-division step: trial subtract of the divisor from the
//          partial remainder with the next dividend bit shifted in.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic            i_bit,
   input  logic [XLEN-1:0] i_div,
   output logic [XLEN-1:0] o_rem,
   output logic            o_q
);

   logic [XLEN:0] w_trial;

   // rem < div always holds, so the shifted value minus div fits in XLEN+1 signed bits
   assign w_trial = {i_rem, i_bit} - {1'b0, i_div};
   assign o_q     = ~w_trial[XLEN];
   assign o_rem   = o_q ? w_trial[XLEN-1:0] : {i_rem[XLEN-2:0], i_bit};

endmodule

`default_nettype wire

// File: rtl/int_div_seq.sv
// ============================================================================
// Module : int_div_seq
// Brief  : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one
//          quotient bit per cycle. Define INT_DIV_EARLY_OUT_EN to finish
//          |a| < |b| operands in one cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module int_div_seq
   import int_div_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result
);

   localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e r_state, w_state_nxt;

   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_rem, r_quo, r_div, r_result;
   logic [1:0]       r_op;
   logic             r_q_neg, r_r_neg;

   logic            w_accept, w_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_abs_a, w_abs_b, w_spec_q, w_spec_r, w_spec_result;
   logic [XLEN-1:0] w_step_rem;
   logic            w_step_q;

   assign o_ready  = (r_state == S_IDLE);
   assign o_valid  = (r_state == S_DONE);
   assign o_result = r_result;

   assign w_accept = i_valid & o_ready & ~i_flush;
   assign w_signed = op_is_signed(i_op);
   assign w_a_neg  = w_signed & i_a[XLEN-1];
   assign w_b_neg  = w_signed & i_b[XLEN-1];
   assign w_abs_a  = w_a_neg ? -i_a : i_a;
   assign w_abs_b  = w_b_neg ? -i_b : i_b;
   assign w_b_zero = (i_b == '0);
   assign w_ovf    = w_signed & (i_a == C_INT_MIN) & (i_b == '1);

   always_comb begin
      w_special = 1'b0;
      w_spec_q  = '1;
      w_spec_r  = i_a;
      if (w_b_zero) begin
         w_special = 1'b1;
      end else if (w_ovf) begin
         w_special = 1'b1;
         w_spec_q  = C_INT_MIN;
         w_spec_r  = '0;
      end
`ifdef INT_DIV_EARLY_OUT_EN
      else if (w_abs_a < w_abs_b) begin
         w_special = 1'b1;
         w_spec_q  = '0;
      end
`endif
   end

   assign w_spec_result = op_is_rem(i_op) ? w_spec_r : w_spec_q;

   div_step #(.XLEN(XLEN)) u_step (
      .i_rem (r_rem),
      .i_bit (r_quo[XLEN-1]),
      .i_div (r_div),
      .o_rem (w_step_rem),
      .o_q   (w_step_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
         S_CALC:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_DONE;
         S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (i_flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_op     <= '0;
         r_q_neg  <= 1'b0;
         r_r_neg  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= i_op;
                  r_q_neg <= w_a_neg ^ w_b_neg;
                  r_r_neg <= w_a_neg;
                  r_rem   <= '0;
                  r_quo   <= w_abs_a;
                  r_div   <= w_abs_b;
                  r_cnt   <= CNT_W'(XLEN);
                  if (w_special) r_result <= w_spec_result;
               end
            end
            S_CALC: begin
               r_rem <= w_step_rem;
               r_quo <= {r_quo[XLEN-2:0], w_step_q};
               r_cnt <= r_cnt - CNT_W'(1);
            end
            S_FIX: begin
               // a flushed op must not disturb the last delivered result
               if (!i_flush) begin
                  if (op_is_rem(r_op)) r_result <= r_r_neg ? -r_rem : r_rem;
                  else                 r_result <= r_q_neg ? -r_quo : r_quo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
